// File: rtl/dram_addr_seq_pkg.sv
// Shared definitions for the DRAM address sequencer.
//   - address mode encodings (mode 3 falls back to sequential)
//   - per-channel state enum
//   - lfsr_taps(k): maximal-length Galois tap mask for k = 8..32, bit k-1 is
//     always set; the register shifts toward bit 0 and folds the dropped bit
//     back in through this mask.
package dram_addr_seq_pkg;

  localparam logic [1:0] MODE_SEQ    = 2'd0;
  localparam logic [1:0] MODE_STRIDE = 2'd1;
  localparam logic [1:0] MODE_LFSR   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_e;

  function automatic logic [31:0] lfsr_taps(input int unsigned k);
    logic [31:0] taps;
    case (k)
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0E08;
      13:      taps = 32'h0000_1C80;
      14:      taps = 32'h0000_3802;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0007_2000;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/dram_addr_seq_if.sv
// Handshake/configuration bundle between the test controller (master) and
// the DRAM address sequencer (slave).
//   i_start/i_mode/i_base/i_stride/i_len : configuration + start pulse
//   i_wen/i_ren                          : address consumed on each channel
//   o_waddr/o_raddr                      : burst-aligned addresses
//   o_wvalid/o_rvalid, o_wdone/o_rdone   : per-channel status
interface dram_addr_seq_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int ALIGN_BITS = 3,
  parameter int LEN_WIDTH  = 24
);
  localparam int K = ADDR_WIDTH - ALIGN_BITS;

  logic                  i_start;
  logic [1:0]            i_mode;
  logic [ADDR_WIDTH-1:0] i_base;
  logic [K-1:0]          i_stride;
  logic [LEN_WIDTH-1:0]  i_len;
  logic                  i_wen;
  logic                  i_ren;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [ADDR_WIDTH-1:0] o_raddr;
  logic                  o_wvalid;
  logic                  o_rvalid;
  logic                  o_wdone;
  logic                  o_rdone;

  modport master (
    output i_start, i_mode, i_base, i_stride, i_len, i_wen, i_ren,
    input  o_waddr, o_raddr, o_wvalid, o_rvalid, o_wdone, o_rdone
  );

  modport slave (
    input  i_start, i_mode, i_base, i_stride, i_len, i_wen, i_ren,
    output o_waddr, o_raddr, o_wvalid, o_rvalid, o_wdone, o_rdone
  );
endinterface

// File: rtl/dram_addr_seq_chan.sv
// One address channel: IDLE -> RUN -> DONE FSM, K-bit unit index and
// transaction counter.
//   clk, i_rst   : clock, synchronous active-high reset
//   start_i      : load seed_i, clear count, enter RUN (overrides consume_i)
//   seed_i       : starting unit index (already zero-seed corrected)
//   mode_i/stride_i/len_i : latched configuration from the top level
//   consume_i    : current index accepted by the downstream mux
//   valid_o/done_o/idx_o/count_o : registered channel status
module dram_addr_seq_chan
  import dram_addr_seq_pkg::*;
#(
  parameter int K         = 24,
  parameter int LEN_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 start_i,
  input  logic [K-1:0]         seed_i,
  input  logic [1:0]           mode_i,
  input  logic [K-1:0]         stride_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 consume_i,
  output logic                 valid_o,
  output logic                 done_o,
  output logic [K-1:0]         idx_o,
  output logic [LEN_WIDTH-1:0] count_o
);

  localparam logic [31:0] TAPS_ALL = lfsr_taps(K);
  localparam logic [K-1:0] TAPS    = TAPS_ALL[K-1:0];

  chan_state_e          state_q, state_d;
  logic [K-1:0]         idx_q, idx_d, idx_next;
  logic [LEN_WIDTH-1:0] count_q, count_d, count_inc;

  assign count_inc = count_q + LEN_WIDTH'(1);

  always_comb begin
    case (mode_i)
      MODE_STRIDE: idx_next = idx_q + stride_i;
      // Galois step from a nonzero state never produces zero.
      MODE_LFSR:   idx_next = (idx_q >> 1) ^ (idx_q[0] ? TAPS : '0);
      default:     idx_next = idx_q + K'(1);
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    if (start_i) begin
      state_d = RUN;
      idx_d   = seed_i;
      count_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (len_i == '0) begin
            state_d = DONE;
          end else if (consume_i) begin
            idx_d   = idx_next;
            count_d = count_inc;
            if (count_inc == len_i) state_d = DONE;
          end
        end
        default: ;  // IDLE and DONE hold until the next start
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Count stays below len while in RUN, so a nonzero len means valid.
  assign valid_o = (state_q == RUN) && (len_i != '0);
  assign done_o  = (state_q == DONE);
  assign idx_o   = idx_q;
  assign count_o = count_q;

endmodule

// File: rtl/dram_addr_sequencer.sv
// Burst-aligned write/read address generator for the DRAM traffic test path.
// Both channels replay the same index sequence (sequential, strided or LFSR).
//   clk, i_rst : clock, synchronous active-high reset
//   bus        : dram_addr_seq_if.slave (configuration, consume strobes,
//                addresses, valid/done per channel)
// Optional build macro DRAM_ADDR_SEQ_RAW_GUARD_EN: hold o_rvalid low while
// the read channel has consumed as many addresses as the write channel.
module dram_addr_sequencer
  import dram_addr_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,  // ADDR_WIDTH-ALIGN_BITS must be 8..32
  parameter int ALIGN_BITS = 3,
  parameter int LEN_WIDTH  = 24
) (
  input logic       clk,
  input logic       i_rst,
  dram_addr_seq_if.slave bus
);

  localparam int K = ADDR_WIDTH - ALIGN_BITS;

  logic [1:0]           mode_q;
  logic [K-1:0]         stride_q;
  logic [LEN_WIDTH-1:0] len_q;

  logic [K-1:0]         base_idx, seed;
  logic                 w_valid, r_valid, raw_ok;
  logic [K-1:0]         w_idx, r_idx;
  logic [LEN_WIDTH-1:0] w_count, r_count;
  logic                 unused_base_lsb;

  assign base_idx        = bus.i_base[ADDR_WIDTH-1:ALIGN_BITS];
  assign unused_base_lsb = ^bus.i_base[ALIGN_BITS-1:0];
  // A zero seed would lock the LFSR at zero forever.
  assign seed = ((bus.i_mode == MODE_LFSR) && (base_idx == '0)) ? K'(1) : base_idx;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      mode_q   <= MODE_SEQ;
      stride_q <= '0;
      len_q    <= '0;
    end else if (bus.i_start) begin
      mode_q   <= bus.i_mode;
      stride_q <= bus.i_stride;
      len_q    <= bus.i_len;
    end
  end

`ifdef DRAM_ADDR_SEQ_RAW_GUARD_EN
  // Counts are registered, so the guard adds no path from i_wen to o_rvalid.
  assign raw_ok = (r_count < w_count);
`else
  logic unused_counts;
  assign raw_ok        = 1'b1;
  assign unused_counts = ^{w_count, r_count};
`endif

  dram_addr_seq_chan #(.K(K), .LEN_WIDTH(LEN_WIDTH)) u_wchan (
    .clk       (clk),
    .i_rst     (i_rst),
    .start_i   (bus.i_start),
    .seed_i    (seed),
    .mode_i    (mode_q),
    .stride_i  (stride_q),
    .len_i     (len_q),
    .consume_i (bus.i_wen),
    .valid_o   (w_valid),
    .done_o    (bus.o_wdone),
    .idx_o     (w_idx),
    .count_o   (w_count)
  );

  dram_addr_seq_chan #(.K(K), .LEN_WIDTH(LEN_WIDTH)) u_rchan (
    .clk       (clk),
    .i_rst     (i_rst),
    .start_i   (bus.i_start),
    .seed_i    (seed),
    .mode_i    (mode_q),
    .stride_i  (stride_q),
    .len_i     (len_q),
    .consume_i (bus.i_ren && raw_ok),
    .valid_o   (r_valid),
    .done_o    (bus.o_rdone),
    .idx_o     (r_idx),
    .count_o   (r_count)
  );

  assign bus.o_waddr  = {w_idx, {ALIGN_BITS{1'b0}}};
  assign bus.o_raddr  = {r_idx, {ALIGN_BITS{1'b0}}};
  assign bus.o_wvalid = w_valid;
  assign bus.o_rvalid = r_valid && raw_ok;

endmodule

// File: tb/tb_dram_addr_sequencer.sv
// Self-checking bench for dram_addr_sequencer: directed steps plus random
// configurations, compared every cycle against a counting reference model.
module tb_dram_addr_sequencer;
  import dram_addr_seq_pkg::*;

  localparam int AW  = 27;
  localparam int AB  = 3;
  localparam int LW  = 24;
  localparam int K   = AW - AB;
  localparam int SAW = 11;
  localparam int SK  = SAW - AB;

  logic clk = 1'b0;
  logic i_rst;
  always #5 clk = ~clk;

  dram_addr_seq_if #(.ADDR_WIDTH(AW),  .ALIGN_BITS(AB), .LEN_WIDTH(LW)) bus ();
  dram_addr_seq_if #(.ADDR_WIDTH(SAW), .ALIGN_BITS(AB), .LEN_WIDTH(LW)) sbus ();

  dram_addr_sequencer #(.ADDR_WIDTH(AW), .ALIGN_BITS(AB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .i_rst(i_rst), .bus(bus));
  dram_addr_sequencer #(.ADDR_WIDTH(SAW), .ALIGN_BITS(AB), .LEN_WIDTH(LW)) sdut (
    .clk(clk), .i_rst(i_rst), .bus(sbus));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A channel is described only by how many addresses it has handed out (n);
  // the address is the n-th element of the mode's sequence.
  bit          m_started = 1'b0;
  int          m_age = 0, m_wn = 0, m_rn = 0, m_len = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [K-1:0] m_seed = '0, m_stride = '0;
  logic [AW-1:0] w_log[$], r_log[$];

  // Galois LFSR: shift toward bit 0; a 1 falling off is folded back via taps.
  function automatic logic [K-1:0] lfsr_step(input logic [K-1:0] v);
    logic [31:0] t;
    t = lfsr_taps(K);
    return v[0] ? ((v >> 1) ^ t[K-1:0]) : (v >> 1);
  endfunction

  function automatic logic [K-1:0] exp_idx(input int n);
    logic [63:0]  acc;
    logic [K-1:0] v;
    case (m_mode)
      2'd1: acc = 64'(m_seed) + 64'(n) * 64'(m_stride);
      2'd2: begin
        v = m_seed;
        for (int i = 0; i < n; i++) v = lfsr_step(v);
        acc = 64'(v);
      end
      default: acc = 64'(m_seed) + 64'(n);
    endcase
    return acc[K-1:0];
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int n);
    return m_started ? {exp_idx(n), {AB{1'b0}}} : '0;
  endfunction

  function automatic bit exp_wvalid();
    return m_started && (m_len != 0) && (m_wn < m_len);
  endfunction

  function automatic bit exp_rvalid();
`ifdef DRAM_ADDR_SEQ_RAW_GUARD_EN
    return m_started && (m_len != 0) && (m_rn < m_len) && (m_rn < m_wn);
`else
    return m_started && (m_len != 0) && (m_rn < m_len);
`endif
  endfunction

  function automatic bit exp_done(input int n);
    if (!m_started) return 1'b0;
    return (m_len == 0) ? (m_age >= 1) : (n == m_len);
  endfunction

  // One clock: drive inputs, let the edge pass, advance the model, compare.
  task automatic cycle(input bit start, input logic [1:0] mode, input logic [AW-1:0] base,
                       input logic [K-1:0] stride, input int len,
                       input bit wen, input bit ren, input string tag);
    bit w_acc, r_acc;
    bus.i_start  = start;
    bus.i_mode   = mode;
    bus.i_base   = base;
    bus.i_stride = stride;
    bus.i_len    = LW'(len);
    bus.i_wen    = wen;
    bus.i_ren    = ren;
    w_acc = !start && wen && exp_wvalid();
    r_acc = !start && ren && exp_rvalid();
    if (w_acc) w_log.push_back(bus.o_waddr);
    if (r_acc) r_log.push_back(bus.o_raddr);
    @(posedge clk);
    #1;
    if (start) begin
      m_started = 1'b1;
      m_age = 0; m_wn = 0; m_rn = 0;
      m_mode = mode; m_stride = stride; m_len = len;
      m_seed = base[AW-1:AB];
      if (mode == 2'd2 && m_seed == '0) m_seed = K'(1);
    end else begin
      if (m_started) m_age++;
      if (w_acc) m_wn++;
      if (r_acc) m_rn++;
    end
    bus.i_start = 1'b0;
    bus.i_wen   = 1'b0;
    bus.i_ren   = 1'b0;
    check({tag, " wvalid"}, 64'(bus.o_wvalid), 64'(exp_wvalid()));
    check({tag, " rvalid"}, 64'(bus.o_rvalid), 64'(exp_rvalid()));
    check({tag, " wdone"},  64'(bus.o_wdone),  64'(exp_done(m_wn)));
    check({tag, " rdone"},  64'(bus.o_rdone),  64'(exp_done(m_rn)));
    check({tag, " waddr"},  64'(bus.o_waddr),  64'(exp_addr(m_wn)));
    check({tag, " raddr"},  64'(bus.o_raddr),  64'(exp_addr(m_rn)));
  endtask

  task automatic idle(input int n, input bit wen, input bit ren, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, m_mode, '0, '0, m_len, wen, ren, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SK-1:0] wq[$], rq[$];
    int            seen[256];
    int            guard;
    logic [1:0]    r_mode;
    logic [AW-1:0] r_base;
    logic [K-1:0]  r_stride;
    int            r_len;

    bus.i_start = 0; bus.i_mode = 0; bus.i_base = '0; bus.i_stride = '0;
    bus.i_len = '0; bus.i_wen = 0; bus.i_ren = 0;
    sbus.i_start = 0; sbus.i_mode = 0; sbus.i_base = '0; sbus.i_stride = '0;
    sbus.i_len = '0; sbus.i_wen = 0; sbus.i_ren = 0;

    // Reset: every output low/zero.
    i_rst = 1'b1;
    idle(3, 1'b1, 1'b1, "reset");
    i_rst = 1'b0;
    idle(2, 1'b1, 1'b1, "idle");

    // Sequential, base 0x100, len 4, i_wen held high.
    w_log.delete();
    cycle(1'b1, 2'd0, 27'h100, '0, 4, 1'b0, 1'b0, "seq start");
    idle(4, 1'b1, 1'b0, "seq run");
    check("seq count", 64'(w_log.size()), 64'd4);
    if (w_log.size() == 4) begin
      check("seq a0", 64'(w_log[0]), 64'h100);
      check("seq a1", 64'(w_log[1]), 64'h108);
      check("seq a2", 64'(w_log[2]), 64'h110);
      check("seq a3", 64'(w_log[3]), 64'h118);
    end
    idle(3, 1'b1, 1'b0, "seq done hold");

    // Strided: base 0, stride 3, len 3; reads every other cycle.
    r_log.delete();
    cycle(1'b1, 2'd1, '0, K'(3), 3, 1'b0, 1'b0, "stride start");
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'd1, '0, K'(3), 3, 1'b1, (i % 2) == 0, "stride run");
    check("stride rcount", 64'(r_log.size()), 64'd3);
    if (r_log.size() == 3) begin
      check("stride r0", 64'(r_log[0]), 64'h00);
      check("stride r1", 64'(r_log[1]), 64'h18);
      check("stride r2", 64'(r_log[2]), 64'h30);
    end

    // Strided wrap at the top of the address space.
    w_log.delete();
    cycle(1'b1, 2'd1, 27'h7FFFFF8, K'(1), 2, 1'b0, 1'b0, "wrap start");
    idle(3, 1'b1, 1'b0, "wrap run");
    if (w_log.size() == 2) check("wrap next", 64'(w_log[1]), 64'h0);
    else check("wrap count", 64'(w_log.size()), 64'd2);

    // Restart mid-RUN with a simultaneous consume.
    cycle(1'b1, 2'd0, 27'h2000, '0, 10, 1'b0, 1'b0, "rs start");
    idle(3, 1'b1, 1'b1, "rs run");
    cycle(1'b1, 2'd0, 27'h4000, '0, 5, 1'b1, 1'b1, "rs restart");
    check("restart base", 64'(bus.o_waddr), 64'h4000);
    idle(6, 1'b1, 1'b1, "rs run2");

    // len = 0: valid never rises, done two cycles after start.
    cycle(1'b1, 2'd0, 27'h500, '0, 0, 1'b0, 1'b0, "len0 start");
    check("len0 not done yet", 64'(bus.o_wdone), 64'd0);
    idle(4, 1'b1, 1'b1, "len0 run");
    check("len0 addr hold", 64'(bus.o_waddr), 64'h500);

`ifdef DRAM_ADDR_SEQ_RAW_GUARD_EN
    // Reads may never overtake writes.
    r_log.delete();
    cycle(1'b1, 2'd0, 27'h800, '0, 8, 1'b0, 1'b0, "raw start");
    idle(2, 1'b1, 1'b1, "raw w2");
    idle(4, 1'b0, 1'b1, "raw wait");
    check("raw reads", 64'(r_log.size()), 64'd2);
    check("raw rvalid low", 64'(bus.o_rvalid), 64'd0);
    idle(1, 1'b1, 1'b0, "raw w3");
    check("raw rvalid high", 64'(bus.o_rvalid), 64'd1);
`endif

    // Randomized configurations and consume patterns.
    for (int t = 0; t < 40; t++) begin
      r_mode   = 2'($urandom_range(0, 3));
      r_base   = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom());
      r_stride = ($urandom_range(0, 1) == 0) ? K'($urandom_range(0, 9)) : K'($urandom());
      r_len    = $urandom_range(0, 10);
      cycle(1'b1, r_mode, r_base, r_stride, r_len, 1'($urandom_range(0, 1)), 1'b1, "rand start");
      for (int c = 0; c < r_len * 3 + 4; c++) begin
        if ($urandom_range(0, 49) == 0) begin
          r_len = $urandom_range(1, 6);
          cycle(1'b1, r_mode, AW'($urandom()), r_stride, r_len, 1'b1, 1'b1, "rand restart");
        end else begin
          cycle(1'b0, r_mode, '0, '0, r_len, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, "rand run");
        end
      end
    end

    // Small instance, K=8 LFSR: full period from the zero-seed fixup.
    sbus.i_mode  = 2'd2;
    sbus.i_base  = '0;
    sbus.i_len   = LW'(255);
    sbus.i_start = 1'b1;
    @(posedge clk); #1;
    sbus.i_start = 1'b0;
    check("lfsr seed addr", 64'(sbus.o_waddr), 64'h008);
    guard = 0;
    while (!(sbus.o_wdone && sbus.o_rdone) && guard < 1000) begin
      sbus.i_wen = 1'b1;
      sbus.i_ren = 1'b1;
      if (sbus.o_wvalid) wq.push_back(sbus.o_waddr[SAW-1:AB]);
      if (sbus.o_rvalid) rq.push_back(sbus.o_raddr[SAW-1:AB]);
      check("lfsr waddr align", 64'(sbus.o_waddr[AB-1:0]), 64'd0);
      @(posedge clk); #1;
      guard++;
    end
    sbus.i_wen = 1'b0;
    sbus.i_ren = 1'b0;
    check("lfsr finished", 64'(sbus.o_wdone && sbus.o_rdone), 64'd1);
    check("lfsr wlen", 64'(wq.size()), 64'd255);
    check("lfsr rlen", 64'(rq.size()), 64'd255);
    foreach (seen[v]) seen[v] = 0;
    foreach (wq[i]) seen[wq[i]]++;
    check("lfsr zero never", 64'(seen[0]), 64'd0);
    for (int v = 1; v < 256; v++) check("lfsr once", 64'(seen[v]), 64'd1);
    for (int i = 0; i < 255 && i < wq.size() && i < rq.size(); i++)
      check("lfsr r==w", 64'(rq[i]), 64'(wq[i]));
    check("lfsr period back to seed", 64'(sbus.o_waddr), 64'h008);

    // Synchronous reset in the middle of a run.
    cycle(1'b1, 2'd0, 27'h1230, '0, 9, 1'b0, 1'b0, "pre-reset start");
    idle(2, 1'b1, 1'b1, "pre-reset run");
    i_rst = 1'b1;
    m_started = 1'b0; m_wn = 0; m_rn = 0; m_age = 0;
    idle(2, 1'b1, 1'b1, "mid reset");
    i_rst = 1'b0;
    idle(1, 1'b1, 1'b1, "post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_addr_sequencer.md
Name: dram_addr_sequencer

Overview:
- Successor to the free-running write/read address counter used by the DRAM traffic test path.
- Generates burst-aligned DRAM addresses for one write channel and one read channel. Both channels replay the identical sequence, so read data can be compared against the write pattern.
- Adds three address modes (sequential, strided, LFSR pseudo-random), a base address, a programmable transaction count, and a start/valid/done handshake per channel.
- Sits between the test controller FSM and the DRAM user-interface command mux.

Parameters:
- ADDR_WIDTH, 27, byte address width; ADDR_WIDTH-ALIGN_BITS must be in 8..32.
- ALIGN_BITS, 3, low address bits forced to zero (burst alignment).
- LEN_WIDTH, 24, width of transaction count.

Ports:
- clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_start  in  1  one-cycle pulse: latch configuration, (re)start both channels
- i_mode  in  2  0=sequential, 1=strided, 2=LFSR, 3=treated as sequential
- i_base  in  ADDR_WIDTH  start address; low ALIGN_BITS ignored
- i_stride  in  ADDR_WIDTH-ALIGN_BITS  stride in aligned units (mode 1)
- i_len  in  LEN_WIDTH  transactions per channel
- i_wen  in  1  write address consumed this cycle
- i_ren  in  1  read address consumed this cycle
- o_waddr  out  ADDR_WIDTH  current write address, low ALIGN_BITS = 0
- o_raddr  out  ADDR_WIDTH  current read address, low ALIGN_BITS = 0
- o_wvalid  out  1  o_waddr valid
- o_rvalid  out  1  o_raddr valid
- o_wdone  out  1  write channel finished i_len transactions
- o_rdone  out  1  read channel finished i_len transactions

Behaviour:
- Width: K = ADDR_WIDTH-ALIGN_BITS. Each channel holds a K-bit unit index; output address = {idx, ALIGN_BITS zeros}.
- Reset: both channels go to IDLE; idx=0, counts=0; all outputs 0.
- On i_start:
  - latch mode, stride and len
  - idx <= i_base[ADDR_WIDTH-1:ALIGN_BITS]; in LFSR mode a zero seed is replaced by 1
  - count <= 0; state <= RUN next cycle (o_*valid high one cycle after the start pulse)
- Per-channel FSM: IDLE -> RUN -> DONE.
  - i_start in any state (including mid-RUN) restarts the channel. i_wen/i_ren in the start cycle are ignored.
  - i_len=0: RUN lasts exactly one cycle with valid low, then DONE.
- RUN:
  - o_*valid=1.
  - A consume (i_wen/i_ren) advances idx and count. A consume while valid=0 is ignored.
  - Advance rules:
    - mode 0/3: idx+1 mod 2^K
    - mode 1: idx+stride mod 2^K
    - mode 2: Galois LFSR step, K bits, taps from package; never reaches 0
  - When count reaches len on a consume, the state goes to DONE next cycle. The consume that completes len drops valid the following cycle.
- DONE: valid=0, done=1; held until i_start or reset. idx holds its last advanced value.
- Channels are independent: simultaneous i_wen and i_ren both take effect in the same cycle. The read sequence equals the write sequence element-for-element.
- Address outputs are registered; no combinational path from i_wen/i_ren to any output.

Optional Feature:
- Macro: DRAM_ADDR_SEQ_RAW_GUARD_EN
- Defined: o_rvalid is additionally gated low while rcount >= wcount, so read never overtakes write (read-after-write ordering). o_rdone behaviour is unchanged.
- Undefined: the read channel runs freely, independent of write progress.

Decomposition:
- Package dram_addr_seq_pkg holds:
  - mode localparams SEQ/STRIDE/LFSR
  - channel state enum IDLE/RUN/DONE
  - function lfsr_taps(K) returning a maximal-length tap mask for K=8..32
- Sub-module dram_addr_seq_chan: one channel (FSM, idx, counter, advance logic), instantiated twice. The top-level handles the start latch and the RAW guard.

Test Plan:
- Reset, then start mode 0, base=0x0000100, len=4, i_wen held high -> o_waddr 0x100, 0x108, 0x110, 0x118; o_wvalid falls; o_wdone=1 next cycle.
- Mode 1, base=0, stride=3, len=3, reads consumed every other cycle -> o_raddr 0x00, 0x18, 0x30; rdone after the 3rd consume; wrap case base=0x7FFFFF8, stride=1 -> next address 0x0000000.
- Mode 2, base=0, len=2^K-1 with K=8 (ADDR_WIDTH=11) -> seed 1, every nonzero idx appears exactly once; write and read sequences identical.
- i_start asserted mid-RUN with simultaneous i_wen -> consume ignored; o_waddr returns to the new base; counts restart.
- len=0 -> valid never asserted; done=1 two cycles after start. i_wen while done is ignored and the address holds.
- With DRAM_ADDR_SEQ_RAW_GUARD_EN: i_ren held high, 2 writes issued -> exactly 2 reads accepted; o_rvalid stays low until the 3rd write.
